// File: rtl/uart_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the UART boot loader.
// The master side supplies received bytes; the slave side (the loader) drives the memory port and status.
interface uart_boot_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        hold_cpu;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    modport master (
        output rx_data, rx_valid,
        input  wr_en, wr_addr, wr_data, hold_cpu, done, error, words_loaded
    );

    modport slave (
        input  rx_data, rx_valid,
        output wr_en, wr_addr, wr_data, hold_cpu, done, error, words_loaded
    );
endinterface

// File: rtl/uart_boot_loader.sv
// Loads a checksummed program image from a UART byte stream into instruction memory,
// holding the core in reset until a complete, valid frame has been written.
module uart_boot_loader #(
    parameter logic [31:0] ADDR_BASE      = 32'h0040_0000,
    parameter int unsigned MAX_WORDS      = 64,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    uart_boot_loader_if.slave  bus
);

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TMO_W   = 24;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 24'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q;
    logic [BYTE_W-1:0]   len_lo_q;
    logic [CNT_W-1:0]    len_q;
    logic [BYTE_W-1:0]   chk_q;
    logic [1:0]          idx_q;
    logic [23:0]         word_q;
    logic [TMO_W-1:0]    idle_q;
    logic                wr_en_q;
    logic [31:0]         wr_addr_q;
    logic [31:0]         wr_data_q;
    logic                hold_q;
    logic                done_q;
    logic                error_q;
    logic [CNT_W-1:0]    words_q;

    logic [CNT_W-1:0]    len_d;
    logic                timed_c;
    logic                tmo_hit_c;

    assign len_d     = {bus.rx_data, len_lo_q};
    assign timed_c   = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                       (state_q == S_DATA)   || (state_q == S_CHECK);
    assign tmo_hit_c = timed_c && !bus.rx_valid && (idle_q == TMO_LAST);

    // Frame parser; every decision is taken on the edge carrying an rx_valid strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            len_lo_q  <= '0;
            len_q     <= '0;
            chk_q     <= '0;
            idx_q     <= '0;
            word_q    <= '0;
            idle_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= ADDR_BASE;
            wr_data_q <= '0;
            hold_q    <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            words_q   <= '0;
        end else begin
            wr_en_q <= 1'b0;

            // Advance the write pointer once the strobe cycle has been presented.
            if (wr_en_q) begin
                wr_addr_q <= wr_addr_q + 32'd4;
                words_q   <= words_q + 16'd1;
            end

            if (bus.rx_valid || !timed_c) begin
                idle_q <= '0;
            end else begin
                idle_q <= idle_q + 24'd1;
            end

            case (state_q)
                S_IDLE, S_ERR: begin
                    if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
                        state_q   <= S_LEN_LO;
                        chk_q     <= '0;
                        words_q   <= '0;
                        error_q   <= 1'b0;
                        wr_addr_q <= ADDR_BASE;
                    end
                end
                S_LEN_LO: begin
                    if (bus.rx_valid) begin
                        len_lo_q <= bus.rx_data;
                        state_q  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (bus.rx_valid) begin
                        len_q <= len_d;
                        if (32'(len_d) > MAX_WORDS) begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end else if (len_d == '0) begin
                            state_q <= S_CHECK;
                        end else begin
                            state_q <= S_DATA;
                            idx_q   <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (bus.rx_valid) begin
                        chk_q <= chk_q + bus.rx_data;
                        idx_q <= idx_q + 2'd1;
                        case (idx_q)
                            2'd0: word_q[7:0]   <= bus.rx_data;
                            2'd1: word_q[15:8]  <= bus.rx_data;
                            2'd2: word_q[23:16] <= bus.rx_data;
                            default: begin
                                wr_en_q   <= 1'b1;
                                wr_data_q <= {bus.rx_data, word_q};
                                // Previous word's count update is always complete by byte 3.
                                if ((words_q + 16'd1) == len_q) begin
                                    state_q <= S_CHECK;
                                end
                            end
                        endcase
                    end
                end
                S_CHECK: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data == chk_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                        end else begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (tmo_hit_c) begin
                state_q <= S_ERR;
                error_q <= 1'b1;
            end
        end
    end

    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.hold_cpu     = hold_q;
    assign bus.done         = done_q;
    assign bus.error        = error_q;
    assign bus.words_loaded = words_q;

endmodule
